// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package demux_pkg;

  typedef enum logic {HUNT, LOCKED} demux_state_t;

  typedef logic [1:0] slot_t;

  localparam int NCH = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Two-bit slot counter: advances on each accepted beat, or restarts after
// slot 0 when a frame marker is seen.
module tdm_slot_counter
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  logic  i_load0,
  output slot_t o_count,
  output logic  o_wrap
);

  slot_t r_count;

  // A marker beat is itself slot 0, so the next expected slot is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= i_load0 ? slot_t'(1) : r_count + slot_t'(1);
    end
  end

  assign o_count = r_count;
  assign o_wrap  = i_en & ~i_load0 & (r_count == slot_t'(NCH - 1));

endmodule

// File: rtl/demux1x4_tdm.sv
// Recovers four channels from a slot-multiplexed stream and presents each
// completed frame on registered parallel outputs with a one-cycle strobe.
module demux1x4_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s0,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  demux_state_t     r_state;
  logic [WIDTH-1:0] r_shadow [NCH-1];
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic             r_outValid;
  logic             r_syncErr;

  slot_t w_slot;
  slot_t w_wrIdx;
  logic  w_isLocked;
  logic  w_syncBeat;
  logic  w_en;
  logic  w_wrap;

  assign w_isLocked = (r_state == LOCKED);
  assign w_syncBeat = in_valid & frame_sync;
  // While hunting, only a marker beat is accepted.
  assign w_en       = in_valid & (w_isLocked | frame_sync);
  assign w_wrIdx    = w_syncBeat ? slot_t'(0) : w_slot;

  tdm_slot_counter u_slotCounter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_en),
    .i_load0 (w_syncBeat),
    .o_count (w_slot),
    .o_wrap  (w_wrap)
  );

  // Slot 3 data bypasses the shadow bank and lands straight in d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_outValid <= 1'b0;
      r_syncErr  <= 1'b0;
      for (int i = 0; i < NCH - 1; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_outValid <= 1'b0;
      r_syncErr  <= 1'b0;
      if (w_en) begin
        for (int i = 0; i < NCH - 1; i++) begin
          if (w_wrIdx == slot_t'(i)) begin
            r_shadow[i] <= in_data;
          end
        end
        if (w_wrap) begin
          r_a        <= r_shadow[0];
          r_b        <= r_shadow[1];
          r_c        <= r_shadow[2];
          r_d        <= in_data;
          r_outValid <= 1'b1;
        end
        if (w_syncBeat && w_isLocked && (w_slot != slot_t'(0))) begin
          r_syncErr <= 1'b1;
        end
        if (w_syncBeat) begin
          r_state <= LOCKED;
        end
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign c         = r_c;
  assign d         = r_d;
  assign s1        = w_slot[1];
  assign s0        = w_slot[0];
  assign out_valid = r_outValid;
  assign locked    = w_isLocked;
  assign sync_err  = r_syncErr;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Directed and random checks of demux1x4_tdm against a slot-level frame model.
module tb_demux1x4_tdm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [0:0] in_data = 1'b0;
  logic frame_sync = 1'b0;
  logic [0:0] a, b, c, d;
  logic s1, s0, out_valid, locked, sync_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: frame buffer, expected slot, presented frame.
  bit   mLocked = 1'b0;
  int   mSlot = 0;
  logic mBuf [4] = '{default: 1'b0};
  logic mOut [4] = '{default: 1'b0};
  logic mOv = 1'b0;
  logic mErr = 1'b0;

  demux1x4_tdm #(.WIDTH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .frame_sync (frame_sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .s1         (s1),
    .s0         (s0),
    .out_valid  (out_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] expSlot;
    expSlot = 2'(mSlot);
    checkBit("a", a[0], mOut[0]);
    checkBit("b", b[0], mOut[1]);
    checkBit("c", c[0], mOut[2]);
    checkBit("d", d[0], mOut[3]);
    checkBit("s1", s1, expSlot[1]);
    checkBit("s0", s0, expSlot[0]);
    checkBit("out_valid", out_valid, mOv);
    checkBit("locked", locked, mLocked);
    checkBit("sync_err", sync_err, mErr);
  endtask

  // Drive one cycle, advance the model by the slot rules, then compare.
  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic dt);
    @(negedge clk);
    rst        = r;
    in_valid   = v;
    frame_sync = s;
    in_data    = dt;
    @(posedge clk);
    mOv  = 1'b0;
    mErr = 1'b0;
    if (r) begin
      mLocked = 1'b0;
      mSlot   = 0;
      for (int i = 0; i < 4; i++) begin
        mBuf[i] = 1'b0;
        mOut[i] = 1'b0;
      end
    end else if (v) begin
      if (!mLocked) begin
        if (s) begin
          mBuf[0] = dt;
          mSlot   = 1;
          mLocked = 1'b1;
        end
      end else if (s && mSlot != 0) begin
        mErr    = 1'b1;
        mBuf[0] = dt;
        mSlot   = 1;
      end else begin
        mBuf[mSlot] = dt;
        if (mSlot == 3) begin
          mOut = mBuf;
          mOv  = 1'b1;
        end
        mSlot = (mSlot + 1) % 4;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    // Reset held for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkBit("rst_locked", locked, 1'b0);

    // Hunting: unmarked beats are discarded, then the first marked frame.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkBit("hunt_locked", locked, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkBit("lock_after_sync", locked, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBit("f1_a", a[0], 1'b1);
    checkBit("f1_d", d[0], 1'b0);
    checkBit("f1_strobe", out_valid, 1'b1);
    idle(1);
    checkBit("f1_strobe_gone", out_valid, 1'b0);

    // Back-to-back frames with no idle cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBit("f3_b", b[0], 1'b1);
    checkBit("f3_c", c[0], 1'b1);

    // Gapped beats: slot counter and outputs hold while in_valid is low.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkBit("gap_c", c[0], 1'b0);
    idle(2);

    // Misplaced marker after two beats drops the partial frame.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkBit("resync_err", sync_err, 1'b1);
    checkBit("resync_s0", s0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkBit("resync_a", a[0], 1'b1);
    checkBit("resync_d", d[0], 1'b1);

    // Reset mid-frame, then an unmarked beat must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkBit("midrst_a", a[0], 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkBit("midrst_s0", s0, 1'b0);

    // Random traffic with occasional markers and rare resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
